// File: rtl/gpio_bank.sv
// GPIO bank: OUT/DIR drive registers, synchronised pad inputs,
// sticky edge events with a maskable level interrupt.
module gpio_bank #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             io_wr,
   input  logic             io_rd,
   input  logic [3:0]       addr,
   input  logic [15:0]      wd,
   output logic [15:0]      rd,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq
);

   localparam logic [3:0] A_OUT = 4'd0;
   localparam logic [3:0] A_DIR = 4'd1;
   localparam logic [3:0] A_SET = 4'd2;
   localparam logic [3:0] A_CLR = 4'd3;
   localparam logic [3:0] A_TGL = 4'd4;
   localparam logic [3:0] A_IN  = 4'd5;
   localparam logic [3:0] A_REN = 4'd6;
   localparam logic [3:0] A_FEN = 4'd7;
   localparam logic [3:0] A_EVT = 4'd8;
   localparam logic [3:0] A_IEN = 4'd9;

   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_ren;
   logic [WIDTH-1:0] r_fen;
   logic [WIDTH-1:0] r_evt;
   logic [WIDTH-1:0] r_ien;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];

   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_in;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_evt_set;
   logic [WIDTH-1:0] w_evt_clr;
   logic [WIDTH-1:0] w_rdv;
   logic             w_unused;

   // io_rd is informational; upper wd bits are ignored for narrow banks
   assign w_unused  = ^{io_rd, wd};

   assign w_wd      = wd[WIDTH-1:0];
   assign w_in      = r_sync[SYNC_STAGES-1];
   assign w_rise    = w_in & ~r_prev;
   assign w_fall    = ~w_in & r_prev;
   assign w_evt_set = (w_rise & r_ren) | (w_fall & r_fen);
   assign w_evt_clr = (io_wr && addr == A_EVT) ? w_wd : '0;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= w_in;
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_out <= '0;
         r_dir <= DIR_RESET;
         r_ren <= '0;
         r_fen <= '0;
         r_ien <= '0;
      end else if (io_wr) begin
         case (addr)
            A_OUT:   r_out <= w_wd;
            A_DIR:   r_dir <= w_wd;
            A_SET:   r_out <= r_out | w_wd;
            A_CLR:   r_out <= r_out & ~w_wd;
            A_TGL:   r_out <= r_out ^ w_wd;
            A_REN:   r_ren <= w_wd;
            A_FEN:   r_fen <= w_wd;
            A_IEN:   r_ien <= w_wd;
            default: ;
         endcase
      end
   end

   // set after clear so a same-cycle event survives its clear
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) r_evt <= '0;
      else         r_evt <= (r_evt & ~w_evt_clr) | w_evt_set;
   end

   always_comb begin
      w_rdv = '0;
      case (addr)
         A_OUT:   w_rdv = r_out;
         A_DIR:   w_rdv = r_dir;
         A_IN:    w_rdv = w_in;
         A_REN:   w_rdv = r_ren;
         A_FEN:   w_rdv = r_fen;
         A_EVT:   w_rdv = r_evt;
         A_IEN:   w_rdv = r_ien;
         default: w_rdv = '0;
      endcase
      rd = '0;
      rd[WIDTH-1:0] = w_rdv;
   end

   assign pin_out = r_out;
   assign pin_oe  = r_dir;
   assign irq     = |(r_evt & r_ien);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank (WIDTH=8, SYNC_STAGES=2).
`timescale 1ns/100ps
module tb_gpio_bank;

   logic        clk = 1'b0;
   logic        resetq = 1'b0;
   logic        io_wr = 1'b0;
   logic        io_rd = 1'b0;
   logic [3:0]  addr = 4'd0;
   logic [15:0] wd = 16'd0;
   logic [15:0] rd;
   logic [7:0]  pin_in = 8'h00;
   logic [7:0]  pin_out;
   logic [7:0]  pin_oe;
   logic        irq;

   int n_pass = 0;
   int n_total = 0;

   gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DIR_RESET(8'h00)) dut (
      .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
      .addr(addr), .wd(wd), .rd(rd), .pin_in(pin_in),
      .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      addr = a;
      wd = d;
      io_wr = 1'b1;
      cyc(1);
      io_wr = 1'b0;
   endtask

   task automatic rchk(input string tag, input logic [3:0] a,
                       input logic [15:0] exp);
      addr = a;
      io_rd = 1'b1;
      #1;
      chk(tag, rd, exp);
      io_rd = 1'b0;
   endtask

   logic [15:0] exp036 [10];

   initial begin
      #3;
      chk("rst_pin_out", {8'h0, pin_out}, 16'h0);
      chk("rst_pin_oe", {8'h0, pin_oe}, 16'h0);
      chk("rst_irq", {15'h0, irq}, 16'h0);
      rchk("rst_out", 4'd0, 16'h0);
      cyc(2);
      resetq = 1'b1;
      cyc(1);

      // OUT/SET/CLR/TGL
      wr(4'd0, 16'h000F);
      wr(4'd2, 16'h0030);
      wr(4'd3, 16'h0005);
      wr(4'd4, 16'h0081);
      rchk("out_bb", 4'd0, 16'h00BB);
      chk("pin_out_bb", {8'h0, pin_out}, 16'h00BB);
      rchk("set_rd0", 4'd2, 16'h0);
      rchk("tgl_rd0", 4'd4, 16'h0);

      // DIR and input synchroniser latency
      wr(4'd1, 16'h00F0);
      chk("pin_oe_f0", {8'h0, pin_oe}, 16'h00F0);
      pin_in = 8'hA5;
      cyc(1);
      rchk("in_t1", 4'd5, 16'h0000);
      cyc(1);
      rchk("in_t2", 4'd5, 16'h00A5);

      // rising-edge event on bit 0
      pin_in = 8'hA4;
      cyc(4);
      wr(4'd6, 16'h0001);
      wr(4'd9, 16'h0001);
      rchk("evt_none", 4'd8, 16'h0);
      pin_in = 8'hA5;
      cyc(2);
      chk("irq_t2", {15'h0, irq}, 16'h0);
      cyc(1);
      chk("irq_t3", {15'h0, irq}, 16'h1);
      rchk("evt_t3", 4'd8, 16'h0001);
      pin_in = 8'hA4;
      cyc(4);
      rchk("evt_nofall", 4'd8, 16'h0001);

      // clear racing a new event
      wr(4'd6, 16'h0003);
      pin_in = 8'hA6;
      cyc(4);
      rchk("evt_03", 4'd8, 16'h0003);
      pin_in = 8'hA7;
      cyc(2);
      wr(4'd8, 16'h0001);
      rchk("evt_race", 4'd8, 16'h0003);
      wr(4'd8, 16'h0003);
      rchk("evt_clr", 4'd8, 16'h0000);
      chk("irq_clr", {15'h0, irq}, 16'h0);

      // reset mid-operation
      wr(4'd0, 16'h00FF);
      wr(4'd6, 16'h000F);
      pin_in = 8'hA0;
      cyc(4);
      pin_in = 8'hAF;
      cyc(4);
      rchk("evt_0f", 4'd8, 16'h000F);
      chk("irq_pre", {15'h0, irq}, 16'h1);
      addr = 4'd0;
      wd = 16'h0055;
      io_wr = 1'b1;
      resetq = 1'b0;
      #1;
      chk("rst_now_pout", {8'h0, pin_out}, 16'h0);
      chk("rst_now_irq", {15'h0, irq}, 16'h0);
      chk("rst_now_oe", {8'h0, pin_oe}, 16'h0);
      cyc(1);
      io_wr = 1'b0;
      resetq = 1'b1;
      for (int i = 0; i < 10; i++)
         rchk($sformatf("post_rst_%0d", i), 4'(i), 16'h0);
      cyc(4);
      rchk("rel_in", 4'd5, 16'h00AF);
      rchk("rel_noevt", 4'd8, 16'h0);

      // reserved address writes
      wr(4'd0, 16'hFF3C);
      wr(4'd1, 16'h005A);
      wr(4'd6, 16'h0011);
      wr(4'd7, 16'h0022);
      wr(4'd9, 16'h0044);
      wr(4'd12, 16'hFFFF);
      wr(4'd10, 16'hFFFF);
      wr(4'd5, 16'hFFFF);
      exp036 = '{16'h003C, 16'h005A, 16'h0, 16'h0, 16'h0,
                 16'h00AF, 16'h0011, 16'h0022, 16'h0, 16'h0044};
      for (int i = 0; i < 10; i++)
         rchk($sformatf("rsv_%0d", i), 4'(i), exp036[i]);
      rchk("rsv_rd12", 4'd12, 16'h0);
      chk("rsv_irq", {15'h0, irq}, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of GPIO lines; legal range 1..16.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 2..4.
REQ-003 SHALL provide parameter DIR_RESET, default all-zero WIDTH bits, reset value of DIR (1 = output).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on posedge clk.
REQ-005 SHALL have port resetq, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port io_wr, input, 1, write strobe for one cycle.
REQ-007 SHALL have port io_rd, input, 1, read strobe; informational only, no side effects.
REQ-008 SHALL have port addr, input, 4, register select.
REQ-009 SHALL have port wd, input, 16, write data; bits above WIDTH-1 ignored.
REQ-010 SHALL have port rd, output, 16, read data, zero-extended above WIDTH-1.
REQ-011 SHALL have port pin_in, input, WIDTH, raw asynchronous pad inputs.
REQ-012 SHALL have port pin_out, output, WIDTH, pad output data, driven from OUT.
REQ-013 SHALL have port pin_oe, output, WIDTH, pad output enables, driven from DIR.
REQ-014 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-015 SHALL decode addr as: 0 OUT r/w; 1 DIR r/w; 2 SET w; 3 CLR w; 4 TGL w; 5 IN r; 6 REN r/w (rising-edge enable); 7 FEN r/w (falling-edge enable); 8 EVT r, write-1-to-clear; 9 IEN r/w (irq mask); 10..15 reserved.
REQ-016 SHALL apply a write at the posedge where io_wr=1, visible on pin_out/pin_oe/rd from the next cycle.
REQ-017 SHALL on SET write perform OUT <= OUT | wd; on CLR OUT <= OUT & ~wd; on TGL OUT <= OUT ^ wd.
REQ-018 SHALL return 0 on rd for SET, CLR, TGL and reserved addresses; writes to IN and reserved addresses SHALL have no effect.
REQ-019 SHALL produce rd combinationally from addr and current register state; zero read latency beyond register update.
REQ-020 SHALL pass each pin_in bit through SYNC_STAGES flip-flops; IN = last stage; pin-to-IN latency exactly SYNC_STAGES cycles.
REQ-021 SHALL hold PREV = IN delayed one cycle; rise[i] = IN[i] & ~PREV[i]; fall[i] = ~IN[i] & PREV[i].
REQ-022 SHALL set EVT[i] on any cycle with (rise[i] & REN[i]) | (fall[i] & FEN[i]); EVT bits sticky until cleared.
REQ-023 SHALL on EVT write clear each EVT bit whose wd bit is 1; an event detected in the same cycle as its clear SHALL win (bit ends set).
REQ-024 SHALL drive irq = OR over i of (EVT[i] & IEN[i]), combinational from registers.
REQ-025 SHALL sample IN regardless of DIR (output lines read back their pad level).
REQ-026 SHALL not generate events from REN/FEN changes alone; only IN/PREV transitions create events.

Reset
REQ-027 SHALL on resetq=0 immediately set OUT=0, DIR=DIR_RESET, REN=0, FEN=0, EVT=0, IEN=0, all synchroniser stages and PREV=0.
REQ-028 SHALL therefore hold pin_out=0, pin_oe=DIR_RESET, irq=0 during and immediately after reset.
REQ-029 SHALL, when a pin is high at reset release, create no event because REN=0 at that time.
REQ-030 SHALL on reset mid-operation (any cycle, including concurrent io_wr) discard the write and enter the reset state.

Verification (WIDTH=8, SYNC_STAGES=2)
REQ-031 Write OUT=0x0F, SET 0x30, CLR 0x05, TGL 0x81 -> OUT reads 0xBB, pin_out=0xBB, rd[15:8]=0.
REQ-032 DIR=0xF0 write; pin_in=0xA5 at cycle t -> IN reads 0x00 at t+1, 0xA5 from t+2; pin_oe=0xF0.
REQ-033 REN=0x01, IEN=0x01; pin_in[0] 0->1 -> EVT=0x01 and irq=1 at t+3; pin_in[0] 1->0 -> no new event (FEN=0).
REQ-034 EVT=0x03 pending; write EVT wd=0x01 same cycle as new rise on bit 0 -> EVT stays 0x03; next write 0x03 -> EVT=0x00, irq=0.
REQ-035 Assert resetq=0 mid-sequence with OUT=0xFF, EVT=0x0F -> same cycle pin_out=0x00, irq=0, all reads 0x00 after release.
REQ-036 Write 0xFFFF to addr 12, then read addr 0..9 -> all registers unchanged; read addr 12 -> 0x0000.
